des_round_engine: RTL and testbench

DES_ROUND_ENGINE -- requirements
Module: des_round_engine

---
 rtl/des_round_engine_if.sv | 22 ++
 rtl/des_round_engine.sv | 191 +++++++++++++++++++
 tb/tb_des_round_engine.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_round_engine_if.sv
// Block-level bus for the DES round engine: request/data in, status/result out.
interface des_round_engine_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key;      // bit 63 is DES key bit 1
  logic [31:0] l_in;     // L0, bit 31 is DES bit 1
  logic [31:0] r_in;     // R0
  logic        busy;
  logic        done;
  logic [31:0] left;     // L16
  logic [31:0] right;    // R16

  modport master (
    output start, decrypt, key, l_in, r_in,
    input  busy, done, left, right
  );

  modport slave (
    input  start, decrypt, key, l_in, r_in,
    output busy, done, left, right
  );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, subkeys generated on the fly
// by rotating C/D forward (encrypt) or backward (decrypt). No final swap.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands and C/D captured on acceptance
// ROUND | one Feistel round per edge, round_q = round being computed
// DONE  | one-cycle result strobe, then back to IDLE
module des_round_engine #(
  parameter int ROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_round_engine_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};

  localparam int P_TAB [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

  localparam int PC1_TAB [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};

  localparam int PC2_TAB [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  // Indexed by {b1,b6,b2,b3,b4,b5} of the 6-bit group, i.e. row*16+col.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [55:0] perm_pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_TAB[i]];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TAB[i]];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    x = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

  // Rounds 1, 2, 9 and 16 of the schedule shift by one, all others by two.
  function automatic logic single_shift(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic        dec_q, dec_d;

  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [55:0] cd_init;

  // Subkey for the current round: forward rotation before PC-2 when
  // encrypting, backward rotation (skipped in round 1) when decrypting.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!dec_q) begin
      if (single_shift(round_q)) begin
        c_rot = {c_q[26:0], c_q[27]};
        d_rot = {d_q[26:0], d_q[27]};
      end else begin
        c_rot = {c_q[25:0], c_q[27:26]};
        d_rot = {d_q[25:0], d_q[27:26]};
      end
    end else if (round_q != 5'd1) begin
      if (single_shift(5'd18 - round_q)) begin
        c_rot = {c_q[0], c_q[27:1]};
        d_rot = {d_q[0], d_q[27:1]};
      end else begin
        c_rot = {c_q[1:0], c_q[27:2]};
        d_rot = {d_q[1:0], d_q[27:2]};
      end
    end
    subkey  = perm_pc2({c_rot, d_rot});
    f_out   = feistel(r_q, subkey);
    cd_init = perm_pc1(bus.key);
  end

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    c_d     = c_q;
    d_d     = d_q;
    l_d     = l_q;
    r_d     = r_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dec_d   = bus.decrypt;
          c_d     = cd_init[55:28];
          d_d     = cd_init[27:0];
          l_d     = bus.l_in;
          r_d     = bus.r_in;
          round_d = 5'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        c_d = c_rot;
        d_d = d_rot;
        l_d = r_q;
        r_d = l_q ^ f_out;
        if (round_q == LAST_ROUND) state_d = DONE;
        else                       round_d = round_q + 5'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      c_q     <= c_d;
      d_q     <= d_d;
      l_q     <= l_d;
      r_q     <= r_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.busy  = (state_q == ROUND);
  assign bus.done  = (state_q == DONE);
  assign bus.left  = l_q;
  assign bus.right = r_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: a behavioural DES model predicts each
// accepted block, a monitor compares results and done timing.
module tb_des_round_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_engine_if bus();

  des_round_engine #(.ROUNDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam int T_E [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
  localparam int T_P [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int T_PC1 [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int T_PC2 [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int T_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int T_S [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  typedef struct packed {
    logic [63:0] res;   // {L16, R16}
    int          due;   // cyc value at the negedge where done must show
  } sb_item_t;

  sb_item_t sb[$];
  int       done_times[$];
  int       cyc = 0;
  int       n_checks = 0;
  int       n_errors = 0;
  int       m_state = 0;   // 0 idle, 1 rounds, 2 done
  int       m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-T_E[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s[31-4*b -: 4] = 4'(T_S[b][row*16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-T_P[i]];
    return p;
  endfunction

  // Textbook form: build K1..K16 by forward rotation, decrypt just reverses them.
  function automatic logic [63:0] m_des(input logic [63:0] key, input logic dec,
                                        input logic [31:0] l, input logic [31:0] r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] lt, rt, tmp;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-T_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < T_SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-T_PC2[j]];
    end
    lt = l;
    rt = r;
    for (int i = 0; i < 16; i++) begin
      tmp = rt;
      rt  = lt ^ m_f(rt, ks[dec ? 15 - i : i]);
      lt  = tmp;
    end
    return {lt, rt};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol model: decides which starts are accepted and queues the prediction.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      sb.delete();
    end else begin
      case (m_state)
        0: if (bus.start) begin
             sb.push_back('{res: m_des(bus.key, bus.decrypt, bus.l_in, bus.r_in), due: cyc + 17});
             m_cnt   <= 0;
             m_state <= 1;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt == 15) m_state <= 2;
           end
        default: m_state <= 0;
      endcase
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_times.push_back(cyc);
      if (sb.size() == 0) begin
        check("done_unexpected", 64'(bus.done), 64'd0);
      end else begin
        check("latency", 64'(cyc), 64'(sb[0].due));
        check("left", 64'(bus.left), 64'(sb[0].res[63:32]));
        check("right", 64'(bus.right), 64'(sb[0].res[31:0]));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      check("done_timeout", 64'(cyc), 64'(sb[0].due));
      void'(sb.pop_front());
    end
  end

  task automatic start_block(input logic [63:0] k, input logic dec,
                             input logic [31:0] l, input logic [31:0] r);
    bus.key     = k;
    bus.decrypt = dec;
    bus.l_in    = l;
    bus.r_in    = r;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      if (sb.size() == 0 && m_state == 0) break;
      @(negedge clk);
    end
    if (i == 60) check("idle_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    bus.key     = '0;
    bus.l_in    = '0;
    bus.r_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_left", 64'(bus.left), 64'd0);
    check("rst_right", 64'(bus.right), 64'd0);
    rst_n = 1'b1;

    // Known-answer encrypt, then outputs must hold after done.
    start_block(KAT_KEY, 1'b0, 32'hCC00CCFF, 32'hF0AAF0AA);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("kat_enc_left_hold", 64'(bus.left), 64'h43423234);
    check("kat_enc_right_hold", 64'(bus.right), 64'h0A4CD995);

    // Known-answer decrypt.
    start_block(KAT_KEY, 1'b1, 32'h0A4CD995, 32'h43423234);
    wait_idle();
    check("kat_dec_left", 64'(bus.left), 64'hF0AAF0AA);
    check("kat_dec_right", 64'(bus.right), 64'hCC00CCFF);

    // Start pulsed during round 5 must be ignored.
    start_block(KAT_KEY, 1'b0, 32'hCC00CCFF, 32'hF0AAF0AA);
    repeat (4) @(negedge clk);
    start_block(64'h0123456789ABCDEF, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    wait_idle();
    check("ignored_start_left", 64'(bus.left), 64'h43423234);
    check("ignored_start_right", 64'(bus.right), 64'h0A4CD995);

    // Reset during round 8 aborts the block.
    start_block(64'hFEDCBA9876543210, 1'b0, 32'h55AA55AA, 32'h0F0F0F0F);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_left", 64'(bus.left), 64'd0);
    check("abort_right", 64'(bus.right), 64'd0);
    rst_n = 1'b1;
    start_block(KAT_KEY, 1'b0, 32'hCC00CCFF, 32'hF0AAF0AA);
    wait_idle();
    check("post_abort_left", 64'(bus.left), 64'h43423234);
    check("post_abort_right", 64'(bus.right), 64'h0A4CD995);

    // Inputs churn every cycle while the block is in flight.
    for (int b = 0; b < 3; b++) begin
      start_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom, $urandom);
      for (int i = 0; i < 17; i++) begin
        bus.key     = {$urandom, $urandom};
        bus.decrypt = 1'($urandom_range(0, 1));
        bus.l_in    = $urandom;
        bus.r_in    = $urandom;
        @(negedge clk);
      end
      wait_idle();
    end

    // Start held high: three blocks, done pulses 18 cycles apart.
    base = done_times.size();
    bus.start = 1'b1;
    for (int i = 0; i < 37; i++) begin
      bus.key     = {$urandom, $urandom};
      bus.decrypt = 1'($urandom_range(0, 1));
      bus.l_in    = $urandom;
      bus.r_in    = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();
    check("b2b_count", 64'(done_times.size() - base), 64'd3);
    for (int i = base + 1; i < done_times.size(); i++)
      check("b2b_gap", 64'(done_times[i] - done_times[i-1]), 64'd18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
